// File: rtl/step_sequencer_if.sv
// step_sequencer_if: pattern-write, transport controls and synth-facing outputs of step_sequencer
interface step_sequencer_if #(
  parameter int STEPS = 16,
  parameter int CNT_W = 12
);
  localparam int AW = $clog2(STEPS);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CNT_W:0]   wr_data;
  logic             run;
  logic [7:0]       tempo;
  logic [7:0]       gate;
  logic [AW:0]      len;
  logic             trig;
  logic [CNT_W-1:0] osc_count;
  logic [AW-1:0]    step;
  logic             busy;
  modport master (
    output wr_en, wr_addr, wr_data, run, tempo, gate, len,
    input  trig, osc_count, step, busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, run, tempo, gate, len,
    output trig, osc_count, step, busy
  );
endinterface

// File: rtl/step_sequencer.sv
// step_sequencer: 16-step pattern player driving synth trig/osc_count; ports clk, rst (async, active-high), bus (step_sequencer_if.slave)
module step_sequencer #(
  parameter int STEPS    = 16,
  parameter int TICK_DIV = 20480,
  parameter int CNT_W    = 12
) (
  input logic            clk,
  input logic            rst,
  step_sequencer_if.slave bus
);
  localparam int AW = $clog2(STEPS);
  localparam int LW = AW + 1;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t           state_q, state_d;
  logic [CNT_W:0]   mem_q [STEPS];
  logic [PW-1:0]    pre_q, pre_d;
  logic [7:0]       tick_q, tick_d;
  logic [AW-1:0]    step_q, step_d, nxt;
  logic [CNT_W-1:0] osc_q, osc_d;
  logic             note_q, note_d, trig_q, trig_d;
  logic [7:0]       t_eff, t_m1;
  logic [LW-1:0]    l_eff, inc;
  logic             last, load;
  always_comb begin
    t_eff   = bus.tempo == 8'd0 ? 8'd1 : bus.tempo;
    t_m1    = t_eff - 8'd1;
    l_eff   = (bus.len == '0 || bus.len > LW'(STEPS)) ? LW'(STEPS) : bus.len;
    inc     = LW'(step_q) + LW'(1);
    nxt     = inc >= l_eff ? '0 : inc[AW-1:0];
    // tick_q can exceed t_m1 after tempo is lowered mid-step; >= ends that step at once
    last    = tick_q >= t_m1 && pre_q == PMAX;
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    step_d  = step_q;
    load    = 1'b0;
    if (state_q == IDLE) begin
      if (bus.run) begin
        state_d = PLAY;
        pre_d   = '0;
        tick_d  = '0;
        step_d  = '0;
        load    = 1'b1;
      end
    end else if (!bus.run) begin
      state_d = IDLE;
    end else begin
      pre_d  = pre_q == PMAX ? '0 : pre_q + PW'(1);
      tick_d = last ? 8'd0 : pre_q == PMAX ? tick_q + 8'd1 : tick_q;
      step_d = last ? nxt : step_q;
      load   = last;
    end
    osc_d  = load ? mem_q[step_d][CNT_W-1:0] : osc_q;
    note_d = load ? mem_q[step_d][CNT_W] : note_q;
    // trig for the upcoming cycle: within gate and never on the step's final cycle
    trig_d = state_d == PLAY && note_d && tick_d < bus.gate &&
             (tick_d < t_m1 || (tick_d == t_m1 && pre_d != PMAX));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= '0;
      step_q  <= '0;
      osc_q   <= '0;
      note_q  <= 1'b0;
      trig_q  <= 1'b0;
      for (int i = 0; i < STEPS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      osc_q   <= osc_d;
      note_q  <= note_d;
      trig_q  <= trig_d;
      if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end
  assign bus.trig      = trig_q;
  assign bus.osc_count = osc_q;
  assign bus.step      = step_q;
  assign bus.busy      = state_q == PLAY;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: scoreboard bench for step_sequencer with TICK_DIV=4
module tb_step_sequencer;
  localparam int TD = 4;
  typedef struct {
    bit    t;
    int    osc;
    int    st;
    bit    b;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t e;
  string tag = "reset";
  int m_note[16];
  int m_cnt[16];
  int Tm = 1, Gm = 0, Lm = 16;
  always #5 clk = ~clk;
  step_sequencer_if #(.STEPS(16), .CNT_W(12)) bus ();
  step_sequencer #(.STEPS(16), .TICK_DIV(TD), .CNT_W(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (bus.trig !== e.t || 32'(bus.osc_count) !== e.osc || 32'(bus.step) !== e.st || bus.busy !== e.b) begin
        failures++;
        $display("FAIL %s: got trig=%0b osc=%0d step=%0d busy=%0b, want trig=%0b osc=%0d step=%0d busy=%0b",
                 e.tag, bus.trig, bus.osc_count, bus.step, bus.busy, e.t, e.osc, e.st, e.b);
      end
    end
  end
  task automatic step_clk();
    @(posedge clk);
    #2;
  endtask
  task automatic push(bit t, int osc, int st, bit b);
    exp_t x;
    x = '{t, osc, st, b, tag};
    q.push_back(x);
  endtask
  function automatic void exp_at(input int i, output bit t, output int osc, output int s);
    int p, c, lim;
    p   = Tm * TD;
    c   = i % p;
    lim = Gm * TD < p - 1 ? Gm * TD : p - 1;
    s   = (i / p) % Lm;
    t   = m_note[s] != 0 && c < lim;
    osc = m_cnt[s];
  endfunction
  task automatic push_play(int i);
    bit t;
    int osc, s;
    exp_at(i, t, osc, s);
    push(t, osc, s, 1'b1);
  endtask
  task automatic cfg(int tempo, int gate, int len);
    bus.tempo = 8'(tempo);
    bus.gate  = 8'(gate);
    bus.len   = 5'(len);
    Tm = tempo == 0 ? 1 : tempo;
    Gm = gate;
    Lm = (len == 0 || len > 16) ? 16 : len;
  endtask
  task automatic wr(int a, int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = 13'(d);
    m_note[a]   = (d >> 12) & 1;
    m_cnt[a]    = d & 'hfff;
    step_clk();
    bus.wr_en = 1'b0;
  endtask
  // play n cycles from a fresh start, optionally writing wdata to waddr at cycle wa;
  // the model sees that entry from cycle ua on; then stop and check the held outputs
  task automatic play(int n, int wa = -1, int waddr = 0, int wdata = 0, int ua = -1);
    bit t;
    int osc, s;
    bus.run = 1'b1;
    step_clk();
    for (int i = 0; i < n; i++) begin
      if (i == ua) begin
        m_note[waddr] = (wdata >> 12) & 1;
        m_cnt[waddr]  = wdata & 'hfff;
      end
      push_play(i);
      bus.wr_en = i == wa;
      if (i == wa) begin
        bus.wr_addr = 4'(waddr);
        bus.wr_data = 13'(wdata);
      end
      step_clk();
    end
    bus.wr_en = 1'b0;
    exp_at(n, t, osc, s);
    push(t, osc, s, 1'b1);
    bus.run = 1'b0;
    step_clk();
    push(1'b0, osc, s, 1'b0);
    step_clk();
    push(1'b0, osc, s, 1'b0);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_note[i] = 0;
      m_cnt[i]  = 0;
    end
    cfg(1, 0, 0);
    step_clk();
    push(1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    step_clk();
    push(1'b0, 0, 0, 1'b0);
    tag = "basic";
    wr(0, 'h1000 | 100);
    wr(1, 'h1000 | 200);
    cfg(3, 2, 2);
    play(39);
    tag = "restart";
    play(24);
    tag = "legato";
    cfg(2, 255, 2);
    play(24);
    tag = "rest";
    wr(1, 300);
    play(24);
    tag = "gate0";
    cfg(2, 0, 2);
    play(16);
    tag = "tempo0_len0";
    wr(1, 'h1000 | 200);
    cfg(0, 1, 0);
    play(68);
    tag = "len_over";
    cfg(1, 1, 17);
    play(68);
    tag = "live_write";
    wr(1, 300);
    cfg(1, 1, 2);
    play(16, 1, 0, 'h1000 | 555, 4);
    tag = "reset_mid";
    cfg(3, 2, 2);
    bus.run = 1'b1;
    step_clk();
    for (int i = 0; i < 5; i++) begin
      push_play(i);
      step_clk();
    end
    rst = 1'b1;
    bus.run = 1'b0;
    #1;
    push(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      m_note[i] = 0;
      m_cnt[i]  = 0;
    end
    step_clk();
    push(1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    tag = "cleared";
    cfg(1, 255, 0);
    play(64);
    step_clk();
    step_clk();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
